// File: rtl/icache_dm_if.sv
// CPU instruction-fetch port and physical-memory line port of icache_dm.
interface icache_dm_if;
  // CPU instruction port
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  // Physical-memory line port (read only)
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  // Environment side: CPU requester plus line memory
  modport master (
    output mem_read, mem_address,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_address,
    output pmem_resp, pmem_rdata
  );

  // Cache side
  modport slave (
    input  mem_read, mem_address,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_address,
    input  pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with 256-bit lines held in flops.
// Misses refill the whole line from physical memory; hit and miss counters wrap.
module icache_dm #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_dm_if.slave  bus,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int unsigned S     = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 27 - S;

  typedef enum logic {IDLE, FILL} state_e;

  state_e              state_q;
  logic [31:0]         req_addr_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [255:0]        data_q [NUM_SETS];
  logic                mem_resp_q;
  logic [31:0]         mem_rdata_q;
  logic [31:0]         hit_count_q;
  logic [31:0]         miss_count_q;

  // Address fields of the incoming fetch and of the latched miss
  logic [S-1:0]     set_idx;
  logic [TAG_W-1:0] tag_in;
  logic [2:0]       word_idx;
  logic [S-1:0]     req_set;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       req_word;
  logic             hit;
  logic             fill_done;
  logic             unused_addr_bits;

  assign set_idx  = bus.mem_address[5 +: S];
  assign tag_in   = bus.mem_address[31 -: TAG_W];
  assign word_idx = bus.mem_address[4:2];
  assign req_set  = req_addr_q[5 +: S];
  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_word = req_addr_q[4:2];

  assign hit       = valid_q[set_idx] && (tag_q[set_idx] == tag_in);
  assign fill_done = (state_q == FILL) && bus.pmem_resp;

  // Byte offset within a word is irrelevant to word fetches
  assign unused_addr_bits = ^{bus.mem_address[1:0], req_addr_q[1:0]};

  // Control FSM: lookup in IDLE, wait for the line in FILL; outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      req_addr_q   <= '0;
      mem_resp_q   <= 1'b0;
      mem_rdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      mem_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mem_read) begin
            if (hit) begin
              mem_rdata_q <= data_q[set_idx][{word_idx, 5'b0} +: 32];
              mem_resp_q  <= 1'b1;
              hit_count_q <= hit_count_q + 32'd1;
            end else begin
              req_addr_q   <= bus.mem_address;
              miss_count_q <= miss_count_q + 32'd1;
              state_q      <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid_q[req_set] <= 1'b1;
            mem_rdata_q      <= bus.pmem_rdata[{req_word, 5'b0} +: 32];
            mem_resp_q       <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_set]  <= req_tag;
      data_q[req_set] <= bus.pmem_rdata;
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.pmem_read    = (state_q == FILL);
  assign bus.pmem_address = (state_q == FILL) ? {req_addr_q[31:5], 5'b0} : '0;
  assign hit_count_o      = hit_count_q;
  assign miss_count_o     = miss_count_q;

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: stimulus pushes expected responses, a monitor
// pops and compares whenever the cache responds or starts a line read.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  icache_dm_if bus ();

  icache_dm #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  typedef struct {
    logic [31:0] data;
    bit          miss;
    int          issue_cyc;
  } exp_t;

  exp_t        rq[$];
  logic [31:0] pq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          hold_mem = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line memory: answers three cycles into a line read; word w = line address + 0x40 + w
  initial begin
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pmem_read && !hold_mem) begin
        if (cnt == 2) begin
          bus.pmem_resp = 1'b1;
          for (int w = 0; w < 8; w++)
            bus.pmem_rdata[w*32 +: 32] = bus.pmem_address + 32'h40 + w;
          cnt = 0;
        end else begin
          bus.pmem_resp = 1'b0;
          cnt++;
        end
      end else begin
        bus.pmem_resp = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: response data/latency and line-read addresses
  initial begin
    bit   prev_presp;
    bit   prev_pread;
    exp_t e;
    prev_presp = 1'b0;
    prev_pread = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_resp) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h expected no response", bus.mem_rdata);
        end else begin
          e = rq.pop_front();
          check("rdata", bus.mem_rdata, e.data);
          if (e.miss) check("miss_latency", 32'(prev_presp), 32'd1);
          else        check("hit_latency", cyc, e.issue_cyc + 1);
        end
      end
      if (bus.pmem_read && !prev_pread) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pmem_read: got address %h expected no line read", bus.pmem_address);
        end else begin
          check("pmem_address", bus.pmem_address, pq.pop_front());
        end
      end
      prev_presp = bus.pmem_resp;
      prev_pread = bus.pmem_read;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit miss,
                       input logic [31:0] pa);
    exp_t e;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = a;
    e.data      = d;
    e.miss      = miss;
    e.issue_cyc = cyc;
    rq.push_back(e);
    if (miss) pq.push_back(pa);
    @(posedge clk);
    #1 bus.mem_read = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending responses expected 0", rq.size());
      rq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("rst_pmem_address", bus.pmem_address, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    rst_n = 1'b1;

    // Cold miss: set 3, word 1
    issue(32'h64, 32'hA1, 1'b1, 32'h60);
    wait_done();
    check("cold_miss_count", miss_count, 32'd1);
    check("cold_hit_count", hit_count, 32'd0);

    // Hit after fill
    issue(32'h68, 32'hA2, 1'b0, 32'h0);
    wait_done();
    check("hit_count_1", hit_count, 32'd1);
    check("hit_miss_count", miss_count, 32'd1);

    // Conflict eviction in set 3
    issue(32'h164, 32'h1A1, 1'b1, 32'h160);
    wait_done();
    issue(32'h64, 32'hA1, 1'b1, 32'h60);
    wait_done();
    check("conflict_miss_count", miss_count, 32'd3);

    // Back-to-back hits across the whole line
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h60 + 32'(w * 4);
      e.data      = 32'hA0 + 32'(w);
      e.miss      = 1'b0;
      e.issue_cyc = cyc;
      rq.push_back(e);
    end
    @(negedge clk);
    bus.mem_read = 1'b0;
    wait_done();
    check("b2b_hit_count", hit_count, 32'd9);

    // Reset two cycles into a fill
    hold_mem = 1'b1;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h264;
    pq.push_back(32'h260);
    @(posedge clk);
    #1 bus.mem_read = 1'b0;
    @(negedge clk);
    check("fill_pmem_read", 32'(bus.pmem_read), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midfill_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("midfill_hit_count", hit_count, 32'd0);
    check("midfill_miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    hold_mem = 1'b0;
    issue(32'h264, 32'h2A1, 1'b1, 32'h260);
    wait_done();
    check("refetch_miss_count", miss_count, 32'd1);
    check("refetch_hit_count", hit_count, 32'd0);

    // Hit counter wrap
    @(negedge clk);
    force dut.hit_count_q = 32'hFFFF_FFFF;
    #1 release dut.hit_count_q;
    issue(32'h268, 32'h2A2, 1'b0, 32'h0);
    wait_done();
    check("wrap_hit_count", hit_count, 32'd0);
    check("wrap_miss_count", miss_count, 32'd1);

    check("pmem_queue_empty", pq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache sitting directly downstream of the CPU's instruction port (read_a / address_a / resp_a / rdata_a). It serves 32-bit instruction fetches from a local line store. On a miss it fetches a 256-bit line from physical memory over a read-only line port, installs it, and returns the requested word. It also keeps wrap-around hit and miss counters for performance analysis.

## Interface
- NUM_SETS, default 8: number of lines; a power of two, at least 2. S = log2(NUM_SETS).
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- mem_read  in  1: fetch request from the CPU instruction port.
- mem_address  in  32: byte address of the fetch; bits [1:0] are ignored.
- mem_resp  out  1: one-cycle pulse; mem_rdata is valid in this cycle.
- mem_rdata  out  32: fetched instruction word.
- pmem_read  out  1: line-read request to physical memory.
- pmem_address  out  32: line address {tag, set, 5'b0}.
- pmem_resp  in  1: one-cycle pulse; pmem_rdata is valid in this cycle.
- pmem_rdata  in  256: fetched line; word w occupies bits [32w+31:32w].
- hit_count  out  32: count of hits, wraps on overflow.
- miss_count  out  32: count of misses, wraps on overflow.

## Operation
- Address split:
  - offset = addr[4:0]; word = addr[4:2].
  - set = addr[5+S-1:5].
  - tag = addr[31:5+S].
- Storage, all in flops:
  - valid[NUM_SETS];
  - tag[NUM_SETS] of width 27-S;
  - data[NUM_SETS] of width 256.
- FSM states are IDLE and FILL.
- IDLE:
  - Each cycle with mem_read=1 is a sampled request.
  - hit = valid[set] && tag[set]==tag.
  - On a hit: at the edge, register mem_rdata = data[set][word] and mem_resp = 1, increment hit_count, and stay in IDLE.
  - On a miss: at the edge, latch the full address into req_addr, increment miss_count, and go to FILL. mem_resp stays 0.
- FILL:
  - pmem_read = 1 and pmem_address = {req_addr[31:5], 5'b0}, both driven combinationally from the state.
  - mem_read and mem_address are ignored.
  - On the pmem_resp edge, all of the following happen together:
    - data[set] = pmem_rdata, tag[set] = req tag, valid[set] = 1;
    - register mem_rdata = pmem_rdata word req_addr[4:2] and mem_resp = 1;
    - go to IDLE.
  - A miss never counts as a hit after the refill.
- mem_resp is deasserted in every cycle that did not follow a hit or fill completion. mem_rdata holds its last value when mem_resp=0.
- Each sampled request yields exactly one mem_resp. A requester that keeps mem_read high after resp issues a new request, which is normal back-to-back fetching.
- The requester must hold mem_address stable during a miss. If the address changes anyway, the response carries data for the latched req_addr.
- Eviction: a miss replaces the line unconditionally; the cache holds no dirty state.
- No writes; there is no write port.

## Timing
- Reset values (rst_n=0, asynchronous):
  - state = IDLE;
  - all valid = 0;
  - mem_resp = 0, mem_rdata = 0;
  - pmem_read = 0, pmem_address = 0;
  - hit_count = 0, miss_count = 0.
- Tag and data arrays need not be reset.
- Reset mid-FILL: pmem_read drops immediately, no line is installed, and a later pmem_resp is ignored.
- Hit latency: mem_read sampled at edge N gives mem_resp=1 in cycle N+1. Continuous hits give one resp per cycle.
- Miss latency: mem_read sampled at edge N puts pmem_read high from cycle N+1. With pmem_resp at edge M, mem_resp=1 in cycle M+1, and IDLE resumes sampling at edge M+1.
- pmem_read stays high until and including the pmem_resp cycle, and is low in cycle M+1.
- pmem_resp while in IDLE is ignored.
- Counters wrap from 0xFFFFFFFF to 0. Exactly one counter increments per sampled request in IDLE.

## Test plan
- Reset then cold miss:
  - Stimulus: mem_read=1, mem_address=0x00000064 (set 3 for NUM_SETS=8, word 1); memory returns a line whose word w = 0xA0+w after 3 cycles.
  - Required: pmem_address=0x00000060; mem_rdata=0x000000A1 one cycle after pmem_resp; miss_count=1.
- Hit after fill:
  - Stimulus: re-read 0x00000068.
  - Required: mem_resp the next cycle with 0x000000A2, no pmem_read, hit_count=1.
- Conflict eviction:
  - Stimulus: read 0x00000164 (same set, different tag), then 0x00000064.
  - Required: two misses, with pmem_address 0x00000160 then 0x00000060; miss_count increases by 2.
- Back-to-back hits:
  - Stimulus: hold mem_read=1 and step the address 0x60, 0x64 … 0x7C, one per cycle.
  - Required: 8 consecutive resp cycles returning words 0xA0–0xA7.
- Reset mid-fill:
  - Stimulus: assert rst_n=0 two cycles into FILL.
  - Required: pmem_read=0 immediately, counters=0; the same address then misses again.
- Counter wrap:
  - Stimulus: preload hit_count=0xFFFFFFFF via force, then one hit.
  - Required: hit_count=0.
